// File: rtl/icache_if.sv
// Fetch-side and AHB-Lite-side signal bundle for the instruction cache.
// Latency: none (wires only). Backpressure: fetch stalls while imem_ready=0; AHB stalls via hready.
// Ports: slave modport = cache view (drives imem_ready/rdata/err and AHB address/control),
//        master modport = fetch stage plus AHB subordinate view (drives request, flush, hrdata/hready/hresp).
interface icache_if;
   // fetch stage
   logic        imem_ren;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        flush;
   // AHB-Lite manager side
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [2:0]  hburst;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport slave (
      input  imem_ren, imem_addr, flush, hrdata, hready, hresp,
      output imem_ready, imem_rdata, imem_err, haddr, htrans, hsize, hwrite, hburst
   );

   modport master (
      output imem_ren, imem_addr, flush, hrdata, hready, hresp,
      input  imem_ready, imem_rdata, imem_err, haddr, htrans, hsize, hwrite, hburst
   );
endinterface

// File: rtl/icache.sv
// 2-way set-associative instruction cache, 512 sets x one 32-bit word, AHB-Lite refill.
// Latency: hit returns in the request cycle; miss = 2 cycles + bus wait states, then hits.
// Backpressure: imem_ready stays low during miss/flush; AHB address held until hready=1.
// Ports: clk, nrst (async active-low), bus (icache_if.slave): fetch request/response,
//        flush request, and the AHB-Lite single-beat read interface.
module icache #(
   parameter int SETS = 512,   // must equal 2**ICACHE_SET_IDX_W
   parameter int WAYS = 2      // LRU is one bit per set, so this stays 2
) (
   input  logic      clk,
   input  logic      nrst,
   icache_if.slave   bus
);

   localparam int ICACHE_SET_IDX_W = 9;
   localparam int ICACHE_TAG_W     = 32 - ICACHE_SET_IDX_W - 2;
   localparam logic [ICACHE_SET_IDX_W-1:0] LAST_SET = ICACHE_SET_IDX_W'(SETS - 1);

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0]     tag;
      logic [ICACHE_SET_IDX_W-1:0] set_index;
      logic [1:0]                  byte_off;
   } icache_addr_t;

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0] tag;
      logic                    valid;
      logic                    lru;
   } icache_meta_t;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_FLUSH
   } state_t;

   // ------------------------------------------------------------------
   // Storage. Tag/data arrays carry no reset; only valid and lru do.
   // lru[set] names the way to replace next.
   // ------------------------------------------------------------------
   logic [ICACHE_TAG_W-1:0]    tag_q  [WAYS][SETS];
   logic [31:0]                data_q [WAYS][SETS];
   logic [WAYS-1:0][SETS-1:0]  valid_q;
   logic [SETS-1:0]            lru_q;

   state_t                     state_q, state_d;
   icache_addr_t               miss_q, miss_d;
   logic [ICACHE_SET_IDX_W-1:0] cnt_q, cnt_d;
   logic                       pend_q, pend_d;   // flush seen while a bus transfer was in flight

   // Control produced by the FSM for the array writes.
   logic                        fill_we;
   logic                        clr_we;
   logic                        lru_we;
   logic                        lru_val;
   logic [ICACHE_SET_IDX_W-1:0] lru_idx;

   // Response/bus outputs.
   logic        ready;
   logic        err;
   logic [31:0] rdata;
   htrans_t     htrans;

   // ------------------------------------------------------------------
   // Lookup at the current fetch address, victim choice at the miss set.
   // ------------------------------------------------------------------
   icache_addr_t req;
   assign req = bus.imem_addr;

   icache_meta_t lk_meta [WAYS];   // metadata at the request set
   icache_meta_t vm_meta [WAYS];   // metadata at the latched miss set

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         lk_meta[w] = '{tag:   tag_q[w][req.set_index],
                        valid: valid_q[w][req.set_index],
                        lru:   lru_q[req.set_index]};
         vm_meta[w] = '{tag:   tag_q[w][miss_q.set_index],
                        valid: valid_q[w][miss_q.set_index],
                        lru:   lru_q[miss_q.set_index]};
      end
   end

   logic hit0, hit1, hit, hit_way;
   assign hit0    = lk_meta[0].valid && (lk_meta[0].tag == req.tag);
   assign hit1    = lk_meta[1].valid && (lk_meta[1].tag == req.tag);
   assign hit     = hit0 || hit1;
   assign hit_way = hit0 ? 1'b0 : 1'b1;   // way 0 wins if both ever match

   // Fill an invalid way first (way 0 before way 1), otherwise evict per LRU.
   logic victim;
   assign victim = !vm_meta[0].valid ? 1'b0 :
                   !vm_meta[1].valid ? 1'b1 :
                   vm_meta[0].lru;

   // Request and latched miss address match on the word, byte offset ignored.
   logic same_word;
   assign same_word = (req.tag == miss_q.tag) && (req.set_index == miss_q.set_index);

   // Fields that the datapath deliberately does not consume.
   logic unused_bits;
   assign unused_bits = ^{req.byte_off, lk_meta[0].lru, lk_meta[1].lru,
                          vm_meta[0].tag, vm_meta[1].tag, vm_meta[1].lru};

   // ------------------------------------------------------------------
   // FSM next-state and outputs.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      miss_d  = miss_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ready   = 1'b0;
      err     = 1'b0;
      rdata   = '0;
      htrans  = HTRANS_IDLE;
      fill_we = 1'b0;
      clr_we  = 1'b0;
      lru_we  = 1'b0;
      lru_val = 1'b0;
      lru_idx = req.set_index;

      case (state_q)
         S_IDLE: begin
            if (bus.flush) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (bus.imem_ren) begin
               if (hit) begin
                  ready   = 1'b1;
                  rdata   = data_q[hit_way][req.set_index];
                  lru_we  = 1'b1;
                  lru_val = ~hit_way;
               end else begin
                  miss_d  = '{tag: req.tag, set_index: req.set_index, byte_off: 2'b00};
                  state_d = S_ADDR;
               end
            end
         end

         S_ADDR: begin
            htrans = HTRANS_NONSEQ;
            if (bus.flush) pend_d = 1'b1;
            if (bus.hready) state_d = S_DATA;
         end

         S_DATA: begin
            if (bus.flush) pend_d = 1'b1;
            // hready=0 with hresp=1 is the first half of an error response: keep waiting.
            if (bus.hready) begin
               if (!bus.hresp) begin
                  fill_we = 1'b1;
                  lru_we  = 1'b1;
                  lru_idx = miss_q.set_index;
                  lru_val = ~victim;
               end else if (same_word) begin
                  ready = 1'b1;
                  err   = 1'b1;
                  rdata = bus.hrdata;
               end
               if (pend_q || bus.flush) begin
                  state_d = S_FLUSH;
                  cnt_d   = '0;
                  pend_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         S_FLUSH: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_SET) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State, valid and LRU bits (reset).
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         miss_q  <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         valid_q <= '0;
         lru_q   <= '0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         if (clr_we) begin
            valid_q[0][cnt_q] <= 1'b0;
            valid_q[1][cnt_q] <= 1'b0;
            lru_q[cnt_q]      <= 1'b0;
         end
         if (fill_we) valid_q[victim][miss_q.set_index] <= 1'b1;
         if (lru_we)  lru_q[lru_idx] <= lru_val;
      end
   end

   // Tag and data arrays: written only on a successful refill.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[victim][miss_q.set_index]  <= miss_q.tag;
         data_q[victim][miss_q.set_index] <= bus.hrdata;
      end
   end

   // ------------------------------------------------------------------
   // Outputs.
   // ------------------------------------------------------------------
   assign bus.imem_ready = ready;
   assign bus.imem_rdata = rdata;
   assign bus.imem_err   = err;
   assign bus.haddr      = miss_q;   // only meaningful while htrans=NONSEQ; 0 after reset
   assign bus.htrans     = htrans;
   assign bus.hsize      = 3'b010;
   assign bus.hwrite     = 1'b0;
   assign bus.hburst     = 3'b000;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, wait states, LRU conflict, bus error,
// flush during a miss, async reset mid-transfer. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_icache;

   logic clk;
   logic nrst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   bad;

   icache_if bus ();

   icache dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Miss with a zero-wait slave: request cycle misses, one NONSEQ cycle,
   // one data cycle, then the line hits on cycle 3.
   task automatic miss_fill(input string nm, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      bus.imem_ren = 1'b1;
      bus.imem_addr = a;
      bus.hrdata = d;
      bus.hready = 1'b1;
      bus.hresp = 1'b0;
      smp();
      chk({nm, "_c0_ready"}, bus.imem_ready, 0);
      chk({nm, "_c0_err"},   bus.imem_err, 0);
      chk({nm, "_c0_rdata"}, bus.imem_rdata, 0);
      nxt(); smp();
      chk({nm, "_c1_htrans"}, bus.htrans, 2);
      chk({nm, "_c1_haddr"},  bus.haddr, wa);
      nxt(); smp();
      chk({nm, "_c2_ready"},  bus.imem_ready, 0);
      chk({nm, "_c2_htrans"}, bus.htrans, 0);
      nxt(); smp();
      chk({nm, "_c3_ready"}, bus.imem_ready, 1);
      chk({nm, "_c3_rdata"}, bus.imem_rdata, d);
   endtask

   initial begin
      nrst = 1'b0;
      bus.imem_ren = 1'b0;
      bus.imem_addr = '0;
      bus.flush = 1'b0;
      bus.hrdata = '0;
      bus.hready = 1'b1;
      bus.hresp = 1'b0;

      // ---------------- reset state
      #12;
      chk("rst_ready",  bus.imem_ready, 0);
      chk("rst_err",    bus.imem_err, 0);
      chk("rst_rdata",  bus.imem_rdata, 0);
      chk("rst_htrans", bus.htrans, 0);
      chk("rst_haddr",  bus.haddr, 0);
      chk("rst_hsize",  bus.hsize, 3'b010);
      chk("rst_hwrite", bus.hwrite, 0);
      chk("rst_hburst", bus.hburst, 0);
      nxt();
      nrst = 1'b1;

      // ---------------- cold miss, then same-cycle hit
      miss_fill("cold", 32'h0000_0100, 32'h0011_0513);
      nxt(); smp();
      chk("rehit_ready",  bus.imem_ready, 1);
      chk("rehit_rdata",  bus.imem_rdata, 32'h0011_0513);
      chk("rehit_htrans", bus.htrans, 0);

      // ---------------- wait states: 3 in ADDR, 2 in DATA, ready on cycle 8
      nxt();
      bus.imem_addr = 32'h0000_0104;
      bus.hrdata = 32'hA5A5_0001;
      smp();
      chk("ws_c0_ready", bus.imem_ready, 0);
      nxt();
      bus.hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("ws_addr_htrans", bus.htrans, 2);
         chk("ws_addr_haddr",  bus.haddr, 32'h0000_0104);
         nxt();
      end
      bus.hready = 1'b1;
      smp();
      chk("ws_c4_htrans", bus.htrans, 2);
      nxt();
      bus.hready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("ws_data_ready",  bus.imem_ready, 0);
         chk("ws_data_htrans", bus.htrans, 0);
         nxt();
      end
      bus.hready = 1'b1;
      smp();
      chk("ws_c7_ready", bus.imem_ready, 0);
      nxt(); smp();
      chk("ws_c8_ready", bus.imem_ready, 1);
      chk("ws_c8_rdata", bus.imem_rdata, 32'hA5A5_0001);

      // ---------------- conflict / LRU on set 0x40
      nxt();
      miss_fill("fill900", 32'h0000_0900, 32'h9009_0009);
      nxt();
      bus.imem_addr = 32'h0000_0100;
      smp();
      chk("conf_hit100_ready", bus.imem_ready, 1);
      chk("conf_hit100_rdata", bus.imem_rdata, 32'h0011_0513);
      nxt();
      miss_fill("fill1100", 32'h0000_1100, 32'h1111_0011);
      nxt();
      bus.imem_addr = 32'h0000_0100;
      smp();
      chk("conf_keep100_ready", bus.imem_ready, 1);
      chk("conf_keep100_rdata", bus.imem_rdata, 32'h0011_0513);
      nxt();
      miss_fill("conf_evict900", 32'h0000_0900, 32'h9009_0009);

      // ---------------- bus error on 0x200
      nxt();
      bus.imem_addr = 32'h0000_0200;
      smp();
      chk("berr_c0_ready", bus.imem_ready, 0);
      nxt(); smp();
      chk("berr_c1_htrans", bus.htrans, 2);
      chk("berr_c1_haddr",  bus.haddr, 32'h0000_0200);
      nxt();
      bus.hready = 1'b0;
      bus.hresp = 1'b1;
      smp();
      chk("berr_c2_ready", bus.imem_ready, 0);
      chk("berr_c2_err",   bus.imem_err, 0);
      nxt();
      bus.hready = 1'b1;
      bus.hrdata = 32'hDEAD_BEEF;
      smp();
      chk("berr_c3_ready", bus.imem_ready, 1);
      chk("berr_c3_err",   bus.imem_err, 1);
      chk("berr_c3_rdata", bus.imem_rdata, 32'hDEAD_BEEF);
      nxt();
      miss_fill("berr_refetch", 32'h0000_0200, 32'h0000_0293);

      // ---------------- flush during ADDR of a miss on 0x300
      nxt();
      bus.imem_addr = 32'h0000_0300;
      bus.hrdata = 32'h3333_0300;
      smp();
      chk("fl_c0_ready", bus.imem_ready, 0);
      nxt();
      bus.flush = 1'b1;
      bus.hready = 1'b0;
      smp();
      chk("fl_c1_htrans", bus.htrans, 2);
      nxt();
      bus.flush = 1'b0;
      bus.hready = 1'b1;
      smp();
      chk("fl_c2_htrans", bus.htrans, 2);
      chk("fl_c2_haddr",  bus.haddr, 32'h0000_0300);
      nxt(); smp();
      chk("fl_c3_ready", bus.imem_ready, 0);
      nxt();
      bus.imem_addr = 32'h0000_0100;
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         smp();
         if (bus.imem_ready !== 1'b0 || bus.htrans !== 2'b00) bad++;
         nxt();
      end
      bus.hrdata = 32'h0011_0513;
      smp();
      chk("fl_quiet_cycles", bad, 0);
      chk("fl_miss100_ready",  bus.imem_ready, 0);
      chk("fl_miss100_htrans", bus.htrans, 0);
      nxt(); smp();
      chk("fl_len_htrans", bus.htrans, 2);
      chk("fl_len_haddr",  bus.haddr, 32'h0000_0100);
      nxt(); smp();
      nxt(); smp();
      chk("fl_refill_ready", bus.imem_ready, 1);
      chk("fl_refill_rdata", bus.imem_rdata, 32'h0011_0513);
      nxt();
      bus.imem_addr = 32'h0000_0300;
      smp();
      chk("fl_300_gone", bus.imem_ready, 0);
      nxt(); nxt();
      bus.hready = 1'b0;   // park the 0x300 refill in DATA before the reset test

      // ---------------- async reset mid-DATA
      smp();
      chk("ar_pre_htrans", bus.htrans, 0);
      chk("ar_pre_haddr",  bus.haddr, 32'h0000_0300);
      #1 nrst = 1'b0;
      #1;
      chk("ar_ready",  bus.imem_ready, 0);
      chk("ar_htrans", bus.htrans, 0);
      chk("ar_haddr",  bus.haddr, 0);
      nxt();
      nrst = 1'b1;
      bus.hready = 1'b1;
      bus.imem_addr = 32'h0000_0104;
      smp();
      chk("ar_miss104_ready", bus.imem_ready, 0);
      nxt(); smp();
      chk("ar_idle_then_addr_htrans", bus.htrans, 2);
      chk("ar_idle_then_addr_haddr",  bus.haddr, 32'h0000_0104);
      nxt();
      bus.hrdata = 32'hA5A5_0001;
      nxt();
      miss_fill("ar_miss100", 32'h0000_0100, 32'h0011_0513);

      // ---------------- flush beats a hit in IDLE
      nxt();
      bus.flush = 1'b1;
      smp();
      chk("flush_prio_ready", bus.imem_ready, 0);
      chk("flush_prio_rdata", bus.imem_rdata, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
